// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735 sequencer: opcodes, init ROM entry format,
// FSM state encoding and the window-set byte table.
package st7735_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [1:0] {
        ROM_CMD   = 2'b00,
        ROM_DATA  = 2'b01,
        ROM_DELAY = 2'b10,
        ROM_END   = 2'b11
    } rom_type_t;

    typedef struct packed {
        rom_type_t  kind;
        logic [7:0] val;
    } rom_entry_t;

    typedef enum logic [2:0] {
        ST_RST_LO,
        ST_RST_WAIT,
        ST_INIT_FETCH,
        ST_INIT_SEND,
        ST_INIT_DELAY,
        ST_IDLE,
        ST_WIN,
        ST_PIXEL
    } state_t;

    localparam int WIN_BYTES = 11;

    // Returns {dc, byte} for position idx of the CASET/RASET/RAMWR sequence.
    function automatic logic [8:0] win_byte(input logic [3:0] idx,
                                            input logic [15:0] x_end,
                                            input logic [15:0] y_end);
        case (idx)
            4'd0:    win_byte = {1'b0, CMD_CASET};
            4'd1:    win_byte = {1'b1, 8'h00};
            4'd2:    win_byte = {1'b1, 8'h00};
            4'd3:    win_byte = {1'b1, x_end[15:8]};
            4'd4:    win_byte = {1'b1, x_end[7:0]};
            4'd5:    win_byte = {1'b0, CMD_RASET};
            4'd6:    win_byte = {1'b1, 8'h00};
            4'd7:    win_byte = {1'b1, 8'h00};
            4'd8:    win_byte = {1'b1, y_end[15:8]};
            4'd9:    win_byte = {1'b1, y_end[7:0]};
            default: win_byte = {1'b0, CMD_RAMWR};
        endcase
    endfunction

endpackage

// File: rtl/st7735_sequencer_if.sv
// Byte link to the SPI transmitter plus the incoming RGB565 pixel stream.
interface st7735_sequencer_if;
    logic [7:0]  TX_BYTE;
    logic        TX_DC;
    logic        TX_VALID;
    logic        TX_READY;
    logic [15:0] PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_READY;

    modport master (
        output TX_BYTE, TX_DC, TX_VALID, PIX_READY,
        input  TX_READY, PIX_DATA, PIX_VALID
    );

    modport slave (
        input  TX_BYTE, TX_DC, TX_VALID, PIX_READY,
        output TX_READY, PIX_DATA, PIX_VALID
    );
endinterface

// File: rtl/st7735_delay_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module st7735_delay_timer #(
    parameter int             W           = 32,
    parameter logic [W-1:0]   RESET_COUNT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= RESET_COUNT;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);
endmodule

// File: rtl/st7735_sequencer.sv
// ST7735 scheduler: panel reset, init ROM playback, then per-frame window set
// and RGB565 pixel streaming as {DC,byte} over a valid/ready link.
module st7735_sequencer
    import st7735_pkg::*;
#(
    parameter int CLK_MHZ        = 12,
    parameter int RESET_US       = 10,
    parameter int DELAY_SCALE_US = 1000,
    parameter int WIDTH          = 128,
    parameter int HEIGHT         = 160
) (
    input  logic SYSTEM_CLK,
    input  logic RESET,
    input  logic FRAME_START,
    st7735_sequencer_if.master bus,
    output logic LCD_RESET,
    output logic INIT_DONE,
    output logic BUSY,
    output logic FRAME_DONE
);
    localparam int TW           = 32;
    localparam int RESET_CYCLES = RESET_US * CLK_MHZ;
    localparam int DELAY_UNIT   = DELAY_SCALE_US * CLK_MHZ;
    localparam int PIX_TOTAL    = WIDTH * HEIGHT;
    localparam int CNT_W        = $clog2(PIX_TOTAL + 1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_TOTAL);
    localparam logic [15:0]      X_END    = 16'(WIDTH - 1);
    localparam logic [15:0]      Y_END    = 16'(HEIGHT - 1);

    state_t           state_reg;
    logic [3:0]       rom_idx_reg;
    logic [3:0]       win_idx_reg;
    logic [CNT_W-1:0] pix_cnt_reg;
    logic [15:0]      pix_hold_reg;
    logic             pix_full_reg;
    logic             pix_lo_reg;
    logic             pix_ready_reg;
    logic [7:0]       tx_byte_reg;
    logic             tx_dc_reg;
    logic             tx_valid_reg;
    logic             lcd_reset_reg;
    logic             init_done_reg;
    logic             busy_reg;
    logic             frame_done_reg;

    logic             tx_fire;
    logic             tx_slot_free;
    logic             pix_accept;
    rom_entry_t       rom_entry;
    logic             timer_load;
    logic [TW-1:0]    timer_value;
    logic [TW-1:0]    delay_cycles;
    logic             timer_done;

    assign tx_fire      = tx_valid_reg && bus.TX_READY;
    assign tx_slot_free = !tx_valid_reg || bus.TX_READY;
    assign pix_accept   = bus.PIX_VALID && pix_ready_reg;

    always_comb begin
        rom_entry = '{ROM_END, 8'h00};
        case (rom_idx_reg)
            4'd0:  rom_entry = '{ROM_CMD,   CMD_SWRESET};
            4'd1:  rom_entry = '{ROM_DELAY, 8'd150};
            4'd2:  rom_entry = '{ROM_CMD,   CMD_SLPOUT};
            4'd3:  rom_entry = '{ROM_DELAY, 8'd255};
            4'd4:  rom_entry = '{ROM_CMD,   CMD_COLMOD};
            4'd5:  rom_entry = '{ROM_DATA,  8'h05};
            4'd6:  rom_entry = '{ROM_CMD,   CMD_MADCTL};
            4'd7:  rom_entry = '{ROM_DATA,  8'h00};
            4'd8:  rom_entry = '{ROM_CMD,   CMD_DISPON};
            4'd9:  rom_entry = '{ROM_DELAY, 8'd100};
            default: rom_entry = '{ROM_END, 8'h00};
        endcase
    end

    // A state lasting N cycles loads N-1; a zero delay still costs one cycle.
    assign delay_cycles = TW'(rom_entry.val) * TW'(DELAY_UNIT);

    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_reg)
            ST_RST_LO: begin
                if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = TW'(RESET_CYCLES - 1);
                end
            end
            ST_INIT_FETCH: begin
                if (rom_entry.kind == ROM_DELAY) begin
                    timer_load  = 1'b1;
                    timer_value = (delay_cycles == '0) ? '0 : delay_cycles - 1'b1;
                end
            end
            default: ;
        endcase
    end

    st7735_delay_timer #(
        .W           (TW),
        .RESET_COUNT (TW'(RESET_CYCLES - 1))
    ) delay_timer (
        .clk   (SYSTEM_CLK),
        .rst   (RESET),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= ST_RST_LO;
            rom_idx_reg    <= '0;
            win_idx_reg    <= '0;
            pix_cnt_reg    <= '0;
            pix_hold_reg   <= '0;
            pix_full_reg   <= 1'b0;
            pix_lo_reg     <= 1'b0;
            pix_ready_reg  <= 1'b0;
            tx_byte_reg    <= '0;
            tx_dc_reg      <= 1'b0;
            tx_valid_reg   <= 1'b0;
            lcd_reset_reg  <= 1'b0;
            init_done_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (tx_fire) begin
                tx_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_RST_LO: begin
                    if (timer_done) begin
                        lcd_reset_reg <= 1'b1;
                        state_reg     <= ST_RST_WAIT;
                    end
                end
                ST_RST_WAIT: begin
                    if (timer_done) begin
                        rom_idx_reg <= '0;
                        state_reg   <= ST_INIT_FETCH;
                    end
                end
                // The link is always idle here, so a delay starts only after
                // the previous byte has actually transferred.
                ST_INIT_FETCH: begin
                    case (rom_entry.kind)
                        ROM_CMD, ROM_DATA: begin
                            tx_byte_reg  <= rom_entry.val;
                            tx_dc_reg    <= (rom_entry.kind == ROM_DATA);
                            tx_valid_reg <= 1'b1;
                            rom_idx_reg  <= rom_idx_reg + 1'b1;
                            state_reg    <= ST_INIT_SEND;
                        end
                        ROM_DELAY: begin
                            rom_idx_reg <= rom_idx_reg + 1'b1;
                            state_reg   <= ST_INIT_DELAY;
                        end
                        default: begin
                            init_done_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end
                    endcase
                end
                ST_INIT_SEND: begin
                    if (tx_fire) begin
                        state_reg <= ST_INIT_FETCH;
                    end
                end
                ST_INIT_DELAY: begin
                    if (timer_done) begin
                        state_reg <= ST_INIT_FETCH;
                    end
                end
                ST_IDLE: begin
                    if (FRAME_START) begin
                        busy_reg    <= 1'b1;
                        win_idx_reg <= '0;
                        pix_cnt_reg <= '0;
                        state_reg   <= ST_WIN;
                    end
                end
                ST_WIN: begin
                    if (tx_slot_free) begin
                        if (win_idx_reg == 4'(WIN_BYTES)) begin
                            pix_full_reg  <= 1'b0;
                            pix_lo_reg    <= 1'b0;
                            pix_ready_reg <= 1'b1;
                            state_reg     <= ST_PIXEL;
                        end else begin
                            {tx_dc_reg, tx_byte_reg} <= win_byte(win_idx_reg, X_END, Y_END);
                            tx_valid_reg <= 1'b1;
                            win_idx_reg  <= win_idx_reg + 1'b1;
                        end
                    end
                end
                ST_PIXEL: begin
                    if (pix_accept) begin
                        pix_hold_reg  <= bus.PIX_DATA;
                        pix_full_reg  <= 1'b1;
                        pix_ready_reg <= 1'b0;
                        pix_cnt_reg   <= pix_cnt_reg + 1'b1;
                    end
                    if (pix_full_reg && tx_slot_free) begin
                        tx_valid_reg <= 1'b1;
                        tx_dc_reg    <= 1'b1;
                        if (!pix_lo_reg) begin
                            tx_byte_reg <= pix_hold_reg[15:8];
                            pix_lo_reg  <= 1'b1;
                        end else begin
                            tx_byte_reg   <= pix_hold_reg[7:0];
                            pix_lo_reg    <= 1'b0;
                            pix_full_reg  <= 1'b0;
                            pix_ready_reg <= (pix_cnt_reg != PIX_LAST);
                        end
                    end else if (!pix_full_reg && (pix_cnt_reg == PIX_LAST) && tx_fire) begin
                        frame_done_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_RST_LO;
            endcase
        end
    end

    assign bus.TX_BYTE   = tx_byte_reg;
    assign bus.TX_DC     = tx_dc_reg;
    assign bus.TX_VALID  = tx_valid_reg;
    assign bus.PIX_READY = pix_ready_reg;
    assign LCD_RESET     = lcd_reset_reg;
    assign INIT_DONE     = init_done_reg;
    assign BUSY          = busy_reg;
    assign FRAME_DONE    = frame_done_reg;
endmodule

// File: tb/tb_st7735_sequencer.sv
// Scoreboard bench for st7735_sequencer: expected {DC,byte} stream queued at
// stimulus time, checked by a monitor on every TX handshake.
module tb_st7735_sequencer;
    localparam int CLK_MHZ        = 12;
    localparam int RESET_US       = 2;
    localparam int DELAY_SCALE_US = 1;
    localparam int WIDTH          = 4;
    localparam int HEIGHT         = 2;
    localparam int NPIX           = WIDTH * HEIGHT;
    localparam int FRAME_BYTES    = 11 + 2 * NPIX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic lcd_reset, init_done, busy, frame_done;

    st7735_sequencer_if bus();

    st7735_sequencer #(
        .CLK_MHZ(CLK_MHZ), .RESET_US(RESET_US), .DELAY_SCALE_US(DELAY_SCALE_US),
        .WIDTH(WIDTH), .HEIGHT(HEIGHT)
    ) dut (
        .SYSTEM_CLK  (clk),
        .RESET       (rst),
        .FRAME_START (frame_start),
        .bus         (bus),
        .LCD_RESET   (lcd_reset),
        .INIT_DONE   (init_done),
        .BUSY        (busy),
        .FRAME_DONE  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0]  exp_q[$];
    logic [15:0] pix_q[$];
    int          xfer_cyc[$];
    logic [8:0]  xfer_val[$];
    bit          tx_rand = 1'b0;
    bit          pix_rand = 1'b0;
    bit          pix_taken = 1'b0;
    int          frame_done_cnt = 0;
    bit          stall_prev = 1'b0;
    logic [8:0]  held_val = '0;
    bit          fd_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            errors++;
            $display("FAIL %s: got %0d, required >= %0d", name, act, min);
        end
    endtask

    // Transmitter side: TX_READY always 1 or random.
    initial begin
        bus.TX_READY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.TX_READY = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Pixel source: presents the head of pix_q, with random gaps when pix_rand.
    initial begin
        bus.PIX_VALID = 1'b0;
        bus.PIX_DATA  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pix_taken && pix_q.size() > 0) void'(pix_q.pop_front());
            if (pix_q.size() > 0 && (!pix_rand || $urandom_range(0, 2) != 0)) begin
                bus.PIX_VALID = 1'b1;
                bus.PIX_DATA  = pix_q[0];
            end else begin
                bus.PIX_VALID = 1'b0;
                bus.PIX_DATA  = 16'($urandom);
            end
        end
    end

    // Monitor: scoreboard pop on every transfer, hold-stability and FRAME_DONE checks.
    initial begin
        logic [8:0] got;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            pix_taken = bus.PIX_VALID && bus.PIX_READY && !rst;
            if (frame_done) begin
                frame_done_cnt++;
                check("busy_low_with_frame_done", busy, 0);
                check("frame_done_width", fd_prev, 0);
            end
            if (!rst && stall_prev) begin
                check("tx_valid_held", bus.TX_VALID, 1);
                check("tx_data_held", {bus.TX_DC, bus.TX_BYTE}, held_val);
            end
            if (!rst && bus.TX_VALID && bus.TX_READY) begin
                got = {bus.TX_DC, bus.TX_BYTE};
                xfer_cyc.push_back(cyc + 1);
                xfer_val.push_back(got);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got dc=%0d byte=%02h, required no transfer", got[8], got[7:0]);
                end else begin
                    e = exp_q.pop_front();
                    $display("tx %0d @%0d: dc=%0d byte=%02h (expected dc=%0d byte=%02h)",
                             xfer_val.size(), cyc + 1, got[8], got[7:0], e[8], e[7:0]);
                    check("tx_stream", got, e);
                end
            end
            stall_prev = !rst && bus.TX_VALID && !bus.TX_READY;
            held_val   = {bus.TX_DC, bus.TX_BYTE};
            fd_prev    = frame_done;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h3A});
        exp_q.push_back({1'b1, 8'h05});
        exp_q.push_back({1'b0, 8'h36});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b0, 8'h29});
    endtask

    // Reference frame: window over the full panel, then every pixel high byte first.
    task automatic queue_frame(input bit const_pix);
        int xe = WIDTH - 1;
        int ye = HEIGHT - 1;
        logic [15:0] p;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(xe / 256)});
        exp_q.push_back({1'b1, 8'(xe % 256)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(ye / 256)});
        exp_q.push_back({1'b1, 8'(ye % 256)});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < NPIX; i++) begin
            p = const_pix ? 16'hF81F : 16'($urandom);
            pix_q.push_back(p);
            exp_q.push_back({1'b1, 8'(p / 256)});
            exp_q.push_back({1'b1, 8'(p % 256)});
        end
    endtask

    task automatic wait_xfers(input int target, input string name);
        int t = 0;
        while (xfer_val.size() < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_ge(name, xfer_val.size(), target);
    endtask

    task automatic run_frame(input bit rnd, input bit const_pix, input bit poke_mid);
        int base_fd = frame_done_cnt;
        int base_x  = xfer_val.size();
        int t = 0;
        queue_frame(const_pix);
        tx_rand  = rnd;
        pix_rand = rnd;
        pulse_start();
        if (poke_mid) begin
            wait_xfers(base_x + 15, "mid_frame_reached");
            pulse_start();
        end
        while (frame_done_cnt == base_fd && t < 3000) begin
            @(negedge clk);
            t++;
        end
        wait_cycles(30);
        check("frame_done_count", frame_done_cnt - base_fd, 1);
        check("frame_byte_count", xfer_val.size() - base_x, FRAME_BYTES);
        check("frame_exp_drained", exp_q.size(), 0);
        check("frame_pixels_used", pix_q.size(), 0);
        check("busy_after_frame", busy, 0);
        tx_rand  = 1'b0;
        pix_rand = 1'b0;
    endtask

    // Releases reset at a negedge and checks the panel reset pulse and init timing.
    task automatic release_and_init(input bit poke_during_init);
        int low = 0;
        int rise_cyc;
        int base_x = xfer_val.size();
        int t = 0;
        push_init();
        rst = 1'b0;
        while (lcd_reset == 1'b0 && low < 1000) begin
            low++;
            @(negedge clk);
        end
        check("lcd_reset_low_cycles", low, RESET_US * CLK_MHZ);
        rise_cyc = cyc;
        if (poke_during_init) begin
            wait_cycles(200);
            pulse_start();
        end
        while (init_done !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("init_done", init_done, 1);
        check("init_byte_count", xfer_val.size() - base_x, 7);
        check("init_exp_drained", exp_q.size(), 0);
        check("busy_after_init", busy, 0);
        if (xfer_val.size() - base_x >= 7) begin
            check("first_init_byte", xfer_val[base_x], {1'b0, 8'h01});
            check_ge("reset_settle", xfer_cyc[base_x] - rise_cyc, RESET_US * CLK_MHZ);
            check_ge("gap_after_swreset", xfer_cyc[base_x + 1] - xfer_cyc[base_x], 150 * DELAY_SCALE_US * CLK_MHZ);
            check_ge("gap_after_slpout", xfer_cyc[base_x + 2] - xfer_cyc[base_x + 1], 255 * DELAY_SCALE_US * CLK_MHZ);
            check_ge("gap_before_init_done", cyc - xfer_cyc[base_x + 6], 100 * DELAY_SCALE_US * CLK_MHZ);
        end
    endtask

    initial begin
        int base_x;
        wait_cycles(3);
        check("rst_lcd_reset", lcd_reset, 0);
        check("rst_tx_valid", bus.TX_VALID, 0);
        check("rst_tx_byte", bus.TX_BYTE, 0);
        check("rst_tx_dc", bus.TX_DC, 0);
        check("rst_pix_ready", bus.PIX_READY, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        check("rst_frame_done", frame_done, 0);

        release_and_init(1'b1);
        run_frame(1'b0, 1'b1, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0);

        // Reset in the middle of the pixel stream.
        base_x = xfer_val.size();
        queue_frame(1'b0);
        tx_rand  = 1'b1;
        pix_rand = 1'b1;
        pulse_start();
        wait_xfers(base_x + 14, "pixel_phase_reached");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx_valid", bus.TX_VALID, 0);
        check("async_rst_lcd_reset", lcd_reset, 0);
        check("async_rst_busy", busy, 1);
        check("async_rst_pix_ready", bus.PIX_READY, 0);
        exp_q.delete();
        pix_q.delete();
        tx_rand  = 1'b0;
        pix_rand = 1'b0;
        wait_cycles(3);
        release_and_init(1'b0);
        run_frame(1'b1, 1'b0, 1'b0);

        wait_cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
